// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side bundle of the two-port SRAM arbiter.
// Ports 0 (CPU) and 1 (display): req/we/addr/wdata in; gnt/rvalid/rdata out.
interface sram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata0, rdata1
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter/sequencer for a 16-bit async SRAM.
// Ports: clk, rst_n, bus (slave), sram_addr, sram_data, CSX/OEX/WEX.
// Optional SRAM_ARB_RR_EN: round-robin instead of fixed port-0 priority.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              CSX,
  output logic              OEX,
  output logic              WEX
);

  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              drv_q, drv_d;
  logic              csx_q, csx_d;
  logic              oex_q, oex_d;
  logic              wex_q, wex_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick1;
  logic              win_we;

`ifdef SRAM_ARB_RR_EN
  // rr_q remembers the last granted port
  logic rr_q, rr_d;
  assign pick1 = bus.req1 & (~bus.req0 | ~rr_q);
`else
  assign pick1 = bus.req1 & ~bus.req0;
`endif

  assign win_we = pick1 ? bus.we1 : bus.we0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    drv_d    = drv_q;
    csx_d    = csx_q;
    oex_d    = oex_q;
    wex_d    = wex_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef SRAM_ARB_RR_EN
    rr_d     = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          port_d = pick1;
          addr_d = pick1 ? bus.addr1 : bus.addr0;
          dout_d = pick1 ? bus.wdata1 : bus.wdata0;
          gnt0_d = ~pick1;
          gnt1_d = pick1;
`ifdef SRAM_ARB_RR_EN
          rr_d   = pick1;
`endif
          cnt_d  = CNT_MAX;
          csx_d  = 1'b0;
          wex_d  = 1'b1;
          if (win_we) begin
            state_d = WR_SETUP;
            oex_d   = 1'b1;
            drv_d   = 1'b1;
          end else begin
            state_d = RD;
            oex_d   = 1'b0;
            drv_d   = 1'b0;
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          csx_d   = 1'b1;
          oex_d   = 1'b1;
          if (port_q) begin
            rdata1_d = sram_data;
            rv1_d    = 1'b1;
          end else begin
            rdata0_d = sram_data;
            rv0_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        wex_d   = 1'b0;
        cnt_d   = CNT_MAX;
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
          wex_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WR_HOLD: begin
        state_d = IDLE;
        csx_d   = 1'b1;
        drv_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        csx_d   = 1'b1;
        oex_d   = 1'b1;
        wex_d   = 1'b1;
        drv_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      port_q   <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      drv_q    <= 1'b0;
      csx_q    <= 1'b1;
      oex_q    <= 1'b1;
      wex_q    <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef SRAM_ARB_RR_EN
      rr_q     <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      drv_q    <= drv_d;
      csx_q    <= csx_d;
      oex_q    <= oex_d;
      wex_q    <= wex_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef SRAM_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign sram_data = drv_q ? dout_q : {DATA_W{1'bz}};
  assign sram_addr = addr_q;
  assign CSX = csx_q;
  assign OEX = oex_q;
  assign WEX = wex_q;

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rv0_q;
  assign bus.rvalid1 = rv1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with an SRAM model.
// Extra instances at WAIT_CYCLES=0 and 7 check latency scaling.
module tb_sram_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   bad_bus;
  int   bad_dual;

  sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus();
  sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus_a();
  sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus_b();

  logic [17:0] sram_addr, addr_a, addr_b;
  wire  [15:0] sram_data, data_a, data_b;
  logic csx, oex, wex;
  logic csx_a, oex_a, wex_a;
  logic csx_b, oex_b, wex_b;

  sram_arbiter #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .CSX(csx), .OEX(oex), .WEX(wex)
  );

  sram_arbiter #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .sram_addr(addr_a), .sram_data(data_a),
    .CSX(csx_a), .OEX(oex_a), .WEX(wex_a)
  );

  sram_arbiter #(.WAIT_CYCLES(7)) u_w7 (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .sram_addr(addr_b), .sram_data(data_b),
    .CSX(csx_b), .OEX(oex_b), .WEX(wex_b)
  );

  logic [15:0] mem [1024];

  assign sram_data = (!csx && !oex) ?
    mem[sram_addr[9:0]] : 16'hzzzz;

  always @(posedge wex)
    if (!csx) mem[sram_addr[9:0]] <= sram_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_dut.drv_q && !oex) bad_bus++;
      if (bus.gnt0 && bus.gnt1) bad_dual++;
      if (bus.rvalid0 && bus.rvalid1) bad_dual++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start one access at a negedge while the DUT is idle.
  task automatic acc(input bit p, input bit w,
                     input logic [17:0] a,
                     input logic [15:0] d,
                     output int lat, output int wlo,
                     output int g, output logic [17:0] sa);
    lat = 0; wlo = 0; g = 0; sa = '0;
    if (!p) begin
      bus.req0 = 1'b1; bus.we0 = w;
      bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = w;
      bus.addr1 = a; bus.wdata1 = d;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (!wex) wlo++;
      if (bus.gnt0 && !p) begin
        bus.req0 = 1'b0; g++; sa = sram_addr;
      end
      if (bus.gnt1 && p) begin
        bus.req1 = 1'b0; g++; sa = sram_addr;
      end
      if (!w && (p ? bus.rvalid1 : bus.rvalid0)) break;
      if (w && i == 5) break;
    end
  endtask

  int lat, wlo, g, gi, rv0n, g1n, first;
  int ord [5];
  int exp_ord [5];
  int lo_a, lo_b, lat_a, lat_b;
  logic [17:0] sa;
  bit seen;

  initial begin
    n_tests = 0; n_fail = 0;
    bad_bus = 0; bad_dual = 0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    bus.req0 = 0; bus.req1 = 0;
    bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus_a.req0 = 0; bus_a.req1 = 0;
    bus_a.we0 = 0; bus_a.we1 = 0;
    bus_a.addr0 = '0; bus_a.addr1 = '0;
    bus_a.wdata0 = '0; bus_a.wdata1 = '0;
    bus_b.req0 = 0; bus_b.req1 = 0;
    bus_b.we0 = 0; bus_b.we1 = 0;
    bus_b.addr0 = '0; bus_b.addr1 = '0;
    bus_b.wdata0 = '0; bus_b.wdata1 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_csx", csx, 1);
    chk("rst_oex", oex, 1);
    chk("rst_wex", wex, 1);
    chk("rst_drv", u_dut.drv_q, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
    chk("rst_rv", {bus.rvalid0, bus.rvalid1}, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_rdata1", bus.rdata1, 0);

    rst_n = 1'b1;
    @(negedge clk);

    acc(0, 1, 18'h12345, 16'hBEEF, lat, wlo, g, sa);
    chk("wr0_gnt", g, 1);
    chk("wr0_wex_low", wlo, 2);
    chk("wr0_addr", sa, 18'h12345);

    acc(0, 0, 18'h12345, 16'h0, lat, wlo, g, sa);
    chk("rd0_gnt", g, 1);
    chk("rd0_lat", lat, 3);
    chk("rd0_data", bus.rdata0, 16'hBEEF);

    acc(1, 1, 18'h00020, 16'hA5A5, lat, wlo, g, sa);
    chk("wr1_gnt", g, 1);
    acc(1, 0, 18'h00020, 16'h0, lat, wlo, g, sa);
    chk("rd1_lat", lat, 3);
    chk("rd1_data", bus.rdata1, 16'hA5A5);
    chk("rd1_keep0", bus.rdata0, 16'hBEEF);

    // simultaneous reads
`ifdef SRAM_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1, 1};
`else
    exp_ord = '{0, 0, 0, 0, 1};
`endif
    for (int i = 0; i < 5; i++) ord[i] = -1;
    gi = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 18'h12345;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 18'h00020;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.gnt0 && gi < 5) begin ord[gi] = 0; gi++; end
      if (bus.gnt1 && gi < 5) begin ord[gi] = 1; gi++; end
      if (gi == 4) bus.req0 = 0;
      if (gi == 5) begin
        bus.req1 = 0;
        if (bus.rvalid1) break;
      end
    end
    chk("conf_cnt", gi, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("conf_ord%0d", i), ord[i], exp_ord[i]);
    chk("conf_rdata1", bus.rdata1, 16'hA5A5);
    chk("conf_rdata0", bus.rdata0, 16'hBEEF);

    // port 0 read then port 1 write back-to-back
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 18'h12345;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 18'h00777;
    bus.wdata1 = 16'h1357;
    rv0n = 0; g1n = 0; first = -1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.gnt0) begin
        bus.req0 = 0;
        if (first < 0) first = 0;
      end
      if (bus.gnt1) begin
        bus.req1 = 0; g1n++;
        if (first < 0) first = 1;
      end
      if (bus.rvalid0) rv0n++;
    end
    chk("bb_first", first, 0);
    chk("bb_gnt1", g1n, 1);
    chk("bb_rv0", rv0n, 1);
    chk("bb_rdata0", bus.rdata0, 16'hBEEF);
    acc(1, 0, 18'h00777, 16'h0, lat, wlo, g, sa);
    chk("bb_rdback", bus.rdata1, 16'h1357);
    chk("bb_keep0", bus.rdata0, 16'hBEEF);

    // async reset during WR_PULSE
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 18'h00055;
    bus.wdata0 = 16'h0F0F;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.gnt0) bus.req0 = 0;
      if (!wex) begin seen = 1; break; end
    end
    chk("mid_seen_pulse", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wex", wex, 1);
    chk("mid_csx", csx, 1);
    chk("mid_oex", oex, 1);
    chk("mid_drv", u_dut.drv_q, 0);
    chk("mid_addr", sram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // wait-state scaling: writes
    bus_a.req0 = 1; bus_a.we0 = 1; bus_a.addr0 = 18'h1;
    bus_b.req0 = 1; bus_b.we0 = 1; bus_b.addr0 = 18'h1;
    lo_a = 0; lo_b = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus_a.gnt0) bus_a.req0 = 0;
      if (bus_b.gnt0) bus_b.req0 = 0;
      if (!wex_a) lo_a++;
      if (!wex_b) lo_b++;
    end
    chk("w0_wex_low", lo_a, 1);
    chk("w7_wex_low", lo_b, 8);

    // wait-state scaling: reads
    bus_a.req0 = 1; bus_a.we0 = 0;
    bus_b.req0 = 1; bus_b.we0 = 0;
    lat_a = 0; lat_b = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus_a.gnt0) bus_a.req0 = 0;
      if (bus_b.gnt0) bus_b.req0 = 0;
      if (bus_a.rvalid0 && lat_a == 0) lat_a = i;
      if (bus_b.rvalid0 && lat_b == 0) lat_b = i;
    end
    chk("w0_rd_lat", lat_a, 2);
    chk("w7_rd_lat", lat_b, 9);

    chk("no_contention", bad_bus, 0);
    chk("no_dual", bad_dual, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
